mips_mem_responder: RTL and testbench
=====================================

Name: mips_mem_responder

Overview:
- Unified instruction/data memory responder for the multicycle MIPS core; serves both instruction fetch (PC address) and load/store (ALU-out address).
- Captures a request, inserts a parameterised number of wait states, then commits the write or returns the read word, with a one-cycle ready pulse.
- Sits between the datapath/controller and the word-organised storage array.
- Flags misaligned accesses instead of servicing them.

Parameters:
- ADDR_BITS, 8, word-index width; depth = 2**ADDR_BITS 32-bit words.
- WAIT_STATES, 1, extra cycles between acceptance and completion (0..15).
- INIT_FILE, "", optional hex image loaded at elaboration; empty means contents are undefined.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge).
- req  in  1  access request from the controller, sampled when the block can accept.
- mem_write  in  1  1 = store, 0 = load/fetch; captured with req.
- adr  in  32  byte address; captured with req.
- write_data  in  32  store data; captured with req.
- read_data  out  32  load/fetch result; holds its last value between reads.
- ready  out  1  one-cycle completion pulse for the accepted request.
- busy  out  1  high while a request is in flight (WAIT state).
- addr_err  out  1  one-cycle pulse with ready when the captured adr[1:0] != 0.

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, wait counter=0, read_data=0, ready=0, busy=0, addr_err=0. Array contents are not cleared.
- FSM states: IDLE, WAIT, DONE.
- Acceptance:
  - In IDLE or DONE, req==1 captures adr, mem_write and write_data into holding registers.
  - The next state is WAIT when WAIT_STATES>0, otherwise DONE.
  - req in WAIT is ignored; it is not queued.
- WAIT:
  - The counter loads WAIT_STATES-1 on acceptance and decrements each cycle.
  - At 0 the next state is DONE.
  - busy=1 throughout WAIT.
- DONE:
  - ready=1 for exactly this cycle.
  - Read: read_data = array[captured adr[ADDR_BITS+1:2]], registered so it is valid in the same cycle ready is high.
  - Write: the array word is written on the clock edge that ends DONE. read_data is unchanged.
  - Without a new req, the next state is IDLE. With req, a back-to-back request is accepted.
- Latency: acceptance edge to ready = WAIT_STATES+1 cycles.
  - Back-to-back throughput is one access per WAIT_STATES+1 cycles.
- Address rules:
  - Bits above ADDR_BITS+1 are ignored; the address space wraps and aliases.
  - Misaligned (adr[1:0]!=0): still takes full latency. ready=1 and addr_err=1 in DONE. No write commits and read_data is unchanged.
- Timing of inputs: they may change freely after acceptance; only the captured copies are used.
- Read-after-write to the same word, back-to-back: the read returns the newly written data, because the write commits before the read's DONE cycle.
- Reset mid-operation: the in-flight access is aborted, no write commits, and ready is not asserted.

Decomposition:
- Shared package mips_mem_pkg holds:
  - state enum {IDLE, WAIT, DONE};
  - WORD_BYTES=4;
  - alignment-mask constant;
  - default WAIT_STATES.
- One sub-module, mem_array: single-port synchronous RAM (ADDR_BITS, INIT_FILE) with a registered read, we, addr, wdata and rdata.
  - The FSM, counter and holding registers stay in mips_mem_responder.

Test Plan:
- Reset, then store/load with WAIT_STATES=1: write 0xDEADBEEF to adr 0x10, then read adr 0x10.
  - Each ready comes 2 cycles after acceptance; read_data=0xDEADBEEF.
- WAIT_STATES=0, back-to-back reads of adr 0x0 and 0x4 preloaded with 0x11111111 and 0x22222222.
  - ready high on consecutive cycles; read_data follows 0x11111111 then 0x22222222.
- Misaligned store: write 0x12345678 to adr 0x13.
  - ready=1 and addr_err=1 in the same cycle; a later read of 0x10 returns its old value.
- Alias, ADDR_BITS=8: write 0xA5A5A5A5 to adr 0x400.
  - A read of adr 0x0 returns 0xA5A5A5A5.
- Reset mid-operation, WAIT_STATES=3: start a write of 0xCAFEF00D to 0x20, then drive reset low in the second WAIT cycle.
  - No ready; read_data=0; a read of 0x20 returns the pre-write value.
- req pulsed during WAIT is ignored.
  - Exactly one ready per accepted request; busy=1 for WAIT_STATES cycles.

Source files
------------

// File: rtl/mips_mem_responder_pkg.sv
// Shared types and constants for the multicycle MIPS memory responder.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int          WORD_BYTES          = 4;
    localparam logic [1:0]  ALIGN_MASK          = 2'(WORD_BYTES - 1);
    localparam int          DEFAULT_WAIT_STATES = 1;

    function automatic logic is_aligned(input logic [1:0] byte_lo);
        return (byte_lo & ALIGN_MASK) == 2'd0;
    endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// Request/response bundle between the MIPS controller and the memory responder.
interface mips_mem_responder_if;
    logic        req;
    logic        mem_write;
    logic [31:0] adr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        busy;
    logic        addr_err;

    modport master (
        output req, mem_write, adr, write_data,
        input  read_data, ready, busy, addr_err
    );

    modport slave (
        input  req, mem_write, adr, write_data,
        output read_data, ready, busy, addr_err
    );
endinterface

// File: rtl/mips_mem_responder_mem_array.sv
// Word-organised synchronous RAM with a registered read port that doubles as read_data.
module mem_array #(
    parameter int ADDR_BITS = 8,
    parameter     INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [31:0]          rdata
);
    logic [31:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    // With zero wait states a read can be launched on the same edge that commits
    // the previous store; forwarding keeps read-after-write coherent.
    always_ff @(posedge clk) begin
        if (!reset)
            rdata <= 32'd0;
        else if (re)
            rdata <= (we && addr == raddr) ? wdata : mem[raddr];
    end
endmodule

// File: rtl/mips_mem_responder.sv
// Unified fetch/load/store responder: capture, WAIT_STATES wait cycles, then one DONE cycle.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES,
    parameter     INIT_FILE   = ""
) (
    input  logic clk,
    input  logic reset,
    mips_mem_responder_if.slave bus
);
    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] WAIT = ST_WAIT;
    localparam logic [1:0] DONE = ST_DONE;

    localparam logic [3:0] CNT_INIT    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [1:0] ACCEPT_NEXT = (WAIT_STATES > 0) ? WAIT : DONE;

    logic [1:0]           state;
    logic [3:0]           cnt;
    logic                 hold_we;
    logic [ADDR_BITS+1:0] hold_adr;
    logic [31:0]          hold_wdata;

    logic                 accept;
    logic                 enter_done;
    logic [ADDR_BITS+1:0] rd_adr;
    logic                 rd_is_write;
    logic                 ram_re;
    logic                 ram_we;
    logic [31:0]          rdata;
    logic                 unused_hi;

    assign accept = (state != WAIT) && bus.req;

    // The read must land in the register on the edge entering DONE; with no wait
    // states that edge is the acceptance edge, so the live request is used.
    assign enter_done  = (WAIT_STATES == 0) ? accept : (state == WAIT && cnt == 4'd0);
    assign rd_adr      = (WAIT_STATES == 0) ? bus.adr[ADDR_BITS+1:0] : hold_adr;
    assign rd_is_write = (WAIT_STATES == 0) ? bus.mem_write : hold_we;

    assign ram_re = reset && enter_done && !rd_is_write && is_aligned(rd_adr[1:0]);
    assign ram_we = reset && state == DONE && hold_we && is_aligned(hold_adr[1:0]);

    assign unused_hi = ^bus.adr[31:ADDR_BITS+2];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                WAIT: begin
                    if (cnt == 4'd0)
                        state <= DONE;
                    else
                        cnt <= cnt - 4'd1;
                end
                default: begin
                    if (accept) begin
                        state <= ACCEPT_NEXT;
                        cnt   <= CNT_INIT;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            hold_we    <= bus.mem_write;
            hold_adr   <= bus.adr[ADDR_BITS+1:0];
            hold_wdata <= bus.write_data;
        end
    end

    mem_array #(
        .ADDR_BITS (ADDR_BITS),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .addr  (hold_adr[ADDR_BITS+1:2]),
        .wdata (hold_wdata),
        .re    (ram_re),
        .raddr (rd_adr[ADDR_BITS+1:2]),
        .rdata (rdata)
    );

    assign bus.read_data = rdata;
    assign bus.ready     = (state == DONE);
    assign bus.busy      = (state == WAIT);
    assign bus.addr_err  = (state == DONE) && !is_aligned(hold_adr[1:0]);
endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench: three responders (0, 1 and 3 wait states) against a word-array model.
module tb_mips_mem_responder;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_c;
    always #5 clk = ~clk;

    mips_mem_responder_if b0();
    mips_mem_responder_if b1();
    mips_mem_responder_if b2();

    mips_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(1), .INIT_FILE("")) u0 (.clk(clk), .reset(rst_a), .bus(b0));
    mips_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(0), .INIT_FILE("")) u1 (.clk(clk), .reset(rst_a), .bus(b1));
    mips_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(3), .INIT_FILE("")) u2 (.clk(clk), .reset(rst_c), .bus(b2));

    int          pass_cnt = 0;
    int          tot_cnt  = 0;
    logic [31:0] mdl   [3][256];
    bit          known [3][256];
    logic [31:0] exp_rd[3];

    function automatic int ws(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : 3;
    endfunction

    function automatic logic g_ready(input int d);
        return (d == 0) ? b0.ready : (d == 1) ? b1.ready : b2.ready;
    endfunction
    function automatic logic g_busy(input int d);
        return (d == 0) ? b0.busy : (d == 1) ? b1.busy : b2.busy;
    endfunction
    function automatic logic g_err(input int d);
        return (d == 0) ? b0.addr_err : (d == 1) ? b1.addr_err : b2.addr_err;
    endfunction
    function automatic logic [31:0] g_rd(input int d);
        return (d == 0) ? b0.read_data : (d == 1) ? b1.read_data : b2.read_data;
    endfunction

    task automatic drive(input int d, input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd);
        case (d)
            0:       begin b0.req = r; b0.mem_write = w; b0.adr = a; b0.write_data = wd; end
            1:       begin b1.req = r; b1.mem_write = w; b1.adr = a; b1.write_data = wd; end
            default: begin b2.req = r; b2.mem_write = w; b2.adr = a; b2.write_data = wd; end
        endcase
    endtask

    // Called at a negedge; returns at the negedge where ready is seen, so chained
    // calls issue back-to-back requests during the DONE cycle.
    task automatic do_access(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                             input bit noise, output int lat, output int busy_n,
                             output logic err, output logic [31:0] rd);
        logic [7:0] idx;
        drive(d, 1'b1, w, a, wd);
        @(posedge clk);
        #1 drive(d, 1'b0, 1'($urandom), $urandom, $urandom);
        lat = -1; busy_n = 0; err = 1'b0; rd = 32'd0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (g_ready(d)) begin
                lat = k; err = g_err(d); rd = g_rd(d);
                break;
            end
            if (g_busy(d)) busy_n++;
            if (noise) drive(d, 1'($urandom), 1'($urandom), $urandom, $urandom);
        end
        drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
        idx = a[9:2];
        if (a[1:0] == 2'b00) begin
            if (w) begin
                mdl[d][idx]   = wd;
                known[d][idx] = 1'b1;
            end else begin
                exp_rd[d] = known[d][idx] ? mdl[d][idx] : rd;
            end
        end
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0); drive(2, 0, 0, 0, 0);
        rst_a = 1'b0; rst_c = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            tot_cnt++; if (g_ready(d) !== 1'b0) $display("FAIL reset_ready d%0d got %b want 0", d, g_ready(d)); else pass_cnt++;
            tot_cnt++; if (g_busy(d)  !== 1'b0) $display("FAIL reset_busy d%0d got %b want 0", d, g_busy(d));   else pass_cnt++;
            tot_cnt++; if (g_err(d)   !== 1'b0) $display("FAIL reset_err d%0d got %b want 0", d, g_err(d));     else pass_cnt++;
            tot_cnt++; if (g_rd(d) !== 32'd0)   $display("FAIL reset_rdata d%0d got %h want 0", d, g_rd(d));    else pass_cnt++;
            exp_rd[d] = 32'd0;
        end
        rst_a = 1'b1; rst_c = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        int lat, bn; logic err; logic [31:0] rd;
        for (int i = 0; i < 2; i++) begin
            do_access(0, (i == 0), 32'h10, 32'hDEADBEEF, 0, lat, bn, err, rd);
            tot_cnt++; if (lat !== 2) $display("FAIL store_load_latency op%0d got %0d want 2", i, lat); else pass_cnt++;
            tot_cnt++; if (bn !== 1)  $display("FAIL store_load_busy op%0d got %0d want 1", i, bn);    else pass_cnt++;
            tot_cnt++; if (err !== 1'b0) $display("FAIL store_load_err op%0d got %b want 0", i, err);   else pass_cnt++;
        end
        tot_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL store_load_data got %h want deadbeef", rd); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, bn; logic err; logic [31:0] rd;
        do_access(1, 1, 32'h0, 32'h11111111, 0, lat, bn, err, rd);
        do_access(1, 1, 32'h4, 32'h22222222, 0, lat, bn, err, rd);
        tot_cnt++; if (lat !== 1) $display("FAIL b2b_write_latency got %0d want 1", lat); else pass_cnt++;
        @(negedge clk);
        drive(1, 1, 0, 32'h0, 32'h0);
        @(posedge clk);
        #1 drive(1, 1, 0, 32'h4, 32'h0);
        @(negedge clk);
        tot_cnt++; if (b1.ready !== 1'b1) $display("FAIL b2b_ready0 got %b want 1", b1.ready); else pass_cnt++;
        tot_cnt++; if (b1.read_data !== 32'h11111111) $display("FAIL b2b_data0 got %h want 11111111", b1.read_data); else pass_cnt++;
        @(posedge clk);
        #1 drive(1, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        tot_cnt++; if (b1.ready !== 1'b1) $display("FAIL b2b_ready1 got %b want 1", b1.ready); else pass_cnt++;
        tot_cnt++; if (b1.read_data !== 32'h22222222) $display("FAIL b2b_data1 got %h want 22222222", b1.read_data); else pass_cnt++;
        @(negedge clk);
        tot_cnt++; if (b1.ready !== 1'b0) $display("FAIL b2b_ready_drop got %b want 0", b1.ready); else pass_cnt++;
        exp_rd[1] = 32'h22222222;
    endtask

    task automatic test_misaligned();
        int lat, bn; logic err; logic [31:0] rd;
        do_access(0, 1, 32'h13, 32'h12345678, 0, lat, bn, err, rd);
        tot_cnt++; if (lat !== 2)    $display("FAIL misaligned_latency got %0d want 2", lat); else pass_cnt++;
        tot_cnt++; if (err !== 1'b1) $display("FAIL misaligned_err got %b want 1", err);      else pass_cnt++;
        tot_cnt++; if (rd !== exp_rd[0]) $display("FAIL misaligned_rdata_held got %h want %h", rd, exp_rd[0]); else pass_cnt++;
        do_access(0, 0, 32'h10, 32'h0, 0, lat, bn, err, rd);
        tot_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL misaligned_no_commit got %h want deadbeef", rd); else pass_cnt++;
        do_access(2, 0, 32'h22, 32'h0, 0, lat, bn, err, rd);
        tot_cnt++; if (err !== 1'b1 || lat !== 4) $display("FAIL misaligned_read err=%b lat=%0d want 1/4", err, lat); else pass_cnt++;
        tot_cnt++; if (rd !== exp_rd[2]) $display("FAIL misaligned_read_held got %h want %h", rd, exp_rd[2]); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_alias();
        int lat, bn; logic err; logic [31:0] rd;
        do_access(0, 1, 32'h400, 32'hA5A5A5A5, 0, lat, bn, err, rd);
        do_access(0, 0, 32'h0, 32'h0, 0, lat, bn, err, rd);
        tot_cnt++; if (rd !== 32'hA5A5A5A5) $display("FAIL alias_read got %h want a5a5a5a5", rd); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_raw();
        int lat, bn; logic err; logic [31:0] rd, a, wd;
        for (int i = 0; i < 9; i++) begin
            a  = ($urandom & 32'hFFFF_F3FC);
            wd = $urandom;
            do_access(i % 3, 1, a, wd, 0, lat, bn, err, rd);
            do_access(i % 3, 0, a, 32'h0, 0, lat, bn, err, rd);
            tot_cnt++; if (rd !== wd) $display("FAIL raw d%0d adr=%h got %h want %h", i % 3, a, rd, wd); else pass_cnt++;
            tot_cnt++; if (lat !== ws(i % 3) + 1) $display("FAIL raw_latency d%0d got %0d want %0d", i % 3, lat, ws(i % 3) + 1); else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midop();
        int lat, bn, rdy_n; logic err; logic [31:0] rd, pre;
        pre = $urandom;
        do_access(2, 1, 32'h20, pre, 0, lat, bn, err, rd);
        @(negedge clk);
        drive(2, 1, 1, 32'h20, 32'hCAFEF00D);
        @(posedge clk);
        #1 drive(2, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_c = 1'b0;
        @(negedge clk);
        tot_cnt++; if (b2.ready !== 1'b0) $display("FAIL midop_ready got %b want 0", b2.ready); else pass_cnt++;
        tot_cnt++; if (b2.busy !== 1'b0)  $display("FAIL midop_busy got %b want 0", b2.busy);   else pass_cnt++;
        tot_cnt++; if (b2.read_data !== 32'd0) $display("FAIL midop_rdata got %h want 0", b2.read_data); else pass_cnt++;
        rst_c = 1'b1;
        exp_rd[2] = 32'd0;
        rdy_n = 0;
        repeat (6) begin @(negedge clk); if (b2.ready) rdy_n++; end
        tot_cnt++; if (rdy_n !== 0) $display("FAIL midop_stray_ready got %0d want 0", rdy_n); else pass_cnt++;
        do_access(2, 0, 32'h20, 32'h0, 0, lat, bn, err, rd);
        tot_cnt++; if (rd !== pre) $display("FAIL midop_no_commit got %h want %h", rd, pre); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_req_during_wait();
        int lat, bn, d; logic err, w; logic [31:0] rd, a;
        for (int i = 0; i < 8; i++) begin
            d = (i % 2 == 0) ? 2 : 0;
            w = 1'($urandom);
            a = ($urandom & 32'h0000_003C);
            do_access(d, w, a, $urandom, 1, lat, bn, err, rd);
            tot_cnt++; if (lat !== ws(d) + 1) $display("FAIL noise_latency d%0d got %0d want %0d", d, lat, ws(d) + 1); else pass_cnt++;
            tot_cnt++; if (bn !== ws(d)) $display("FAIL noise_busy d%0d got %0d want %0d", d, bn, ws(d)); else pass_cnt++;
            tot_cnt++; if (rd !== exp_rd[d]) $display("FAIL noise_rdata d%0d got %h want %h", d, rd, exp_rd[d]); else pass_cnt++;
            @(negedge clk);
            tot_cnt++; if (g_ready(d) !== 1'b0) $display("FAIL noise_extra_ready d%0d got %b want 0", d, g_ready(d)); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int lat, bn, d; logic err, w; logic [31:0] rd, a;
        for (int i = 0; i < 40; i++) begin
            d = $urandom_range(0, 2);
            w = 1'($urandom);
            a = ($urandom & 32'hFFFF_F03C) | (($urandom_range(0, 4) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            do_access(d, w, a, $urandom, 0, lat, bn, err, rd);
            tot_cnt++; if (lat !== ws(d) + 1) $display("FAIL rand_latency d%0d adr=%h got %0d want %0d", d, a, lat, ws(d) + 1); else pass_cnt++;
            tot_cnt++; if (err !== (a[1:0] != 2'b00)) $display("FAIL rand_err d%0d adr=%h got %b", d, a, err); else pass_cnt++;
            tot_cnt++; if (rd !== exp_rd[d]) $display("FAIL rand_rdata d%0d adr=%h got %h want %h", d, a, rd, exp_rd[d]); else pass_cnt++;
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 256; i++) known[d][i] = 1'b0;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_misaligned();
        test_alias();
        test_raw();
        test_reset_midop();
        test_req_during_wait();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
